// File: rtl/sprite_anim_pkg.sv
// Shared types and elaboration helpers for the sprite animation sequencer.
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    ANIM_HOLD     = 2'd0,
    ANIM_LOOP     = 2'd1,
    ANIM_PINGPONG = 2'd2,
    ANIM_ONESHOT  = 2'd3
  } anim_mode_e;

  typedef enum logic [1:0] {
    ST_RUN_FWD = 2'd0,
    ST_RUN_REV = 2'd1,
    ST_DONE    = 2'd2
  } anim_state_e;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when every frame of every set fits in the ROM address space.
  function automatic bit base_fits(longint unsigned sets, longint unsigned frames,
                                   longint unsigned size, longint unsigned addr_w);
    return (sets * frames * size) <= (64'd1 << addr_w);
  endfunction

endpackage

// File: rtl/sprite_anim_seq_if.sv
// Control and address bus of the sprite animation sequencer.
interface sprite_anim_seq_if #(
  parameter int unsigned NUM_SETS = 2,
  parameter int unsigned FRAMES   = 4,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DIV_W    = 4
);
  localparam int unsigned SET_W   = sprite_anim_pkg::idx_width(NUM_SETS);
  localparam int unsigned FRAME_W = sprite_anim_pkg::idx_width(FRAMES);

  logic                         anim_pulse;
  logic [SET_W-1:0]             set_sel;
  sprite_anim_pkg::anim_mode_e  mode;
  logic [DIV_W-1:0]             rate;
  logic                         restart;
  logic [ADDR_W-1:0]            sprite_addr;
  logic [ADDR_W-1:0]            rom_addr;
  logic [ADDR_W-1:0]            anim_base;
  logic [FRAME_W-1:0]           frame_idx;
  logic                         done;
  logic [7:0]                   cycle_cnt;

  modport master (
    output anim_pulse, set_sel, mode, rate, restart, sprite_addr,
    input  rom_addr, anim_base, frame_idx, done, cycle_cnt
  );

  modport slave (
    input  anim_pulse, set_sel, mode, rate, restart, sprite_addr,
    output rom_addr, anim_base, frame_idx, done, cycle_cnt
  );
endinterface

// File: rtl/anim_prescaler.sv
// Divides anim_pulse by (rate+1) into a single-cycle step strobe.
module anim_prescaler #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pulse,
  input  logic [DIV_W-1:0] rate,
  output logic             step_c
);
  logic [DIV_W-1:0] cnt_q;

  assign step_c = pulse && (cnt_q == rate);

  // Pulse counter; wraps to zero on each step and on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (pulse) begin
      cnt_q <= step_c ? '0 : cnt_q + DIV_W'(1);
    end
  end
endmodule

// File: rtl/sprite_anim_seq.sv
// Animation-frame sequencer producing sprite ROM base offsets.
// Optional completed-cycle counter enabled by SPRITE_ANIM_STATS_EN.
module sprite_anim_seq
  import sprite_anim_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 2,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned FRAME_SIZE = 1020,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DIV_W      = 4
) (
  input logic              clk,
  input logic              resetN,
  sprite_anim_seq_if.slave bus
);
  localparam int unsigned SET_W   = idx_width(NUM_SETS);
  localparam int unsigned FRAME_W = idx_width(FRAMES);
  localparam int unsigned MUL_W   = ADDR_W + 8;
  localparam logic [SET_W-1:0]   LAST_SET   = SET_W'(NUM_SETS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);

  if (!base_fits(NUM_SETS, FRAMES, FRAME_SIZE, ADDR_W)) begin : g_bad_cfg
    $error("sprite_anim_seq: NUM_SETS*FRAMES*FRAME_SIZE exceeds ADDR_W");
  end

  anim_state_e         state_q, state_d;
  anim_mode_e          mode_q;
  logic [SET_W-1:0]    set_q, set_clamped_c;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   base_q;
  logic                clear_c, hold_c, step_c, cycle_inc_c;

  // Out-of-range set selects fall back to the last set.
  always_comb begin
    set_clamped_c = bus.set_sel;
    if (32'(bus.set_sel) >= NUM_SETS) set_clamped_c = LAST_SET;
  end

  assign clear_c = bus.restart || (set_clamped_c != set_q) || (bus.mode != mode_q);
  assign hold_c  = (bus.mode == ANIM_HOLD);

  anim_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (resetN),
    .clear  (clear_c || hold_c),
    .pulse  (bus.anim_pulse),
    .rate   (bus.rate),
    .step_c (step_c)
  );

  // State, frame and base-offset registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_RUN_FWD;
      mode_q  <= ANIM_HOLD;
      set_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= bus.mode;
      set_q   <= set_clamped_c;
      frame_q <= frame_d;
      done_q  <= done_d;
      base_q  <= ADDR_W'((MUL_W'(set_q) * MUL_W'(FRAMES) + MUL_W'(frame_q))
                         * MUL_W'(FRAME_SIZE));
    end
  end

  // Next-state: restart/change/hold beat any step; step advances per mode.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    done_d      = done_q;
    cycle_inc_c = 1'b0;
    if (clear_c || hold_c) begin
      state_d = ST_RUN_FWD;
      frame_d = '0;
      done_d  = 1'b0;
    end else if (step_c) begin
      case (bus.mode)
        ANIM_LOOP: begin
          state_d = ST_RUN_FWD;
          if (frame_q == LAST_FRAME) begin
            frame_d     = '0;
            cycle_inc_c = 1'b1;
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
        ANIM_PINGPONG: begin
          if (FRAMES > 1) begin
            if (state_q == ST_RUN_REV) begin
              frame_d = frame_q - FRAME_W'(1);
              if (frame_q == FRAME_W'(1)) begin
                state_d     = ST_RUN_FWD;
                cycle_inc_c = 1'b1;
              end
            end else begin
              frame_d = frame_q + FRAME_W'(1);
              if (frame_q == LAST_FRAME - FRAME_W'(1)) state_d = ST_RUN_REV;
            end
          end
        end
        ANIM_ONESHOT: begin
          if (state_q != ST_DONE) begin
            if (frame_q != LAST_FRAME) frame_d = frame_q + FRAME_W'(1);
            if ((frame_q == LAST_FRAME) || (frame_q == LAST_FRAME - FRAME_W'(1))) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              cycle_inc_c = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPRITE_ANIM_STATS_EN
  logic [7:0] cycle_q;

  // Saturating count of completed animation cycles.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cycle_q <= '0;
    end else if (clear_c) begin
      cycle_q <= '0;
    end else if (cycle_inc_c && (cycle_q != 8'hFF)) begin
      cycle_q <= cycle_q + 8'd1;
    end
  end

  assign bus.cycle_cnt = cycle_q;
`else
  logic unused_cycle_inc;
  assign unused_cycle_inc = cycle_inc_c;
  assign bus.cycle_cnt    = '0;
`endif

  assign bus.frame_idx = frame_q;
  assign bus.done      = done_q;
  assign bus.anim_base = base_q;
  assign bus.rom_addr  = bus.sprite_addr + base_q;
endmodule

// File: tb/tb_sprite_anim_seq.sv
// Scoreboard bench for sprite_anim_seq.
module tb_sprite_anim_seq;
  import sprite_anim_pkg::*;

  localparam int unsigned NS = 2, FR = 4, FS = 1020, AW = 14, DW = 4;
`ifdef SPRITE_ANIM_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  sprite_anim_seq_if #(.NUM_SETS(NS), .FRAMES(FR), .ADDR_W(AW), .DIV_W(DW)) bus ();

  sprite_anim_seq #(.NUM_SETS(NS), .FRAMES(FR), .FRAME_SIZE(FS), .ADDR_W(AW), .DIV_W(DW)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    int frame;
    int base;
    int done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic int base_of(int set, int frame);
    return ((set * FR + frame) * FS) % (1 << AW);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_once();
    bus.anim_pulse = 1'b1;
    tick();
    bus.anim_pulse = 1'b0;
  endtask

  task automatic test_reset();
    resetN          = 1'b0;
    bus.anim_pulse  = 1'b0;
    bus.set_sel     = '0;
    bus.mode        = ANIM_HOLD;
    bus.rate        = '0;
    bus.restart     = 1'b0;
    bus.sprite_addr = 14'd5;
    #12;
    checks++; if (int'(bus.frame_idx) !== 0) begin errors++; $display("FAIL reset_frame got %0d exp 0", bus.frame_idx); end
    checks++; if (int'(bus.anim_base) !== 0) begin errors++; $display("FAIL reset_base got %0d exp 0", bus.anim_base); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    checks++; if (int'(bus.cycle_cnt) !== 0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", bus.cycle_cnt); end
    checks++; if (int'(bus.rom_addr) !== 5) begin errors++; $display("FAIL reset_rom got %0d exp 5", bus.rom_addr); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_loop();
    int   seq[5] = '{1, 2, 3, 0, 1};
    int   prev;
    exp_t e;
    bus.mode = ANIM_LOOP; bus.set_sel = 1'b1; bus.rate = '0; bus.sprite_addr = 14'd7;
    repeat (3) tick();
    prev = base_of(1, 0);
    for (int i = 0; i < 5; i++) begin
      e.frame = seq[i]; e.base = base_of(1, seq[i]); e.done = 0;
      sb.push_back(e);
      pulse_once();
      e = sb.pop_front();
      checks++; if (int'(bus.frame_idx) !== e.frame) begin errors++; $display("FAIL loop_frame[%0d] got %0d exp %0d", i, bus.frame_idx, e.frame); end
      checks++; if (int'(bus.anim_base) !== prev) begin errors++; $display("FAIL loop_base_lag[%0d] got %0d exp %0d", i, bus.anim_base, prev); end
      tick();
      checks++; if (int'(bus.anim_base) !== e.base) begin errors++; $display("FAIL loop_base[%0d] got %0d exp %0d", i, bus.anim_base, e.base); end
      checks++; if (int'(bus.rom_addr) !== (e.base + 7) % (1 << AW)) begin errors++; $display("FAIL loop_rom[%0d] got %0d exp %0d", i, bus.rom_addr, e.base + 7); end
      prev = e.base;
    end
    checks++; if (int'(bus.cycle_cnt) !== STATS) begin errors++; $display("FAIL loop_cycle got %0d exp %0d", bus.cycle_cnt, STATS); end
  endtask

  task automatic test_pingpong();
    int   pp[7] = '{0, 1, 2, 3, 2, 1, 0};
    exp_t e;
    bus.mode = ANIM_PINGPONG; bus.rate = 4'd1;
    repeat (2) tick();
    for (int k = 1; k <= 12; k++) begin
      e.frame = pp[k / 2]; e.base = base_of(1, pp[k / 2]); e.done = 0;
      sb.push_back(e);
      pulse_once();
      e = sb.pop_front();
      checks++; if (int'(bus.frame_idx) !== e.frame) begin errors++; $display("FAIL pp_frame[%0d] got %0d exp %0d", k, bus.frame_idx, e.frame); end
    end
    tick();
    checks++; if (int'(bus.anim_base) !== base_of(1, 0)) begin errors++; $display("FAIL pp_base got %0d exp %0d", bus.anim_base, base_of(1, 0)); end
    checks++; if (int'(bus.cycle_cnt) !== STATS) begin errors++; $display("FAIL pp_cycle got %0d exp %0d", bus.cycle_cnt, STATS); end
  endtask

  task automatic test_oneshot();
    int   fr[6] = '{1, 2, 3, 3, 3, 3};
    int   dn[6] = '{0, 0, 1, 1, 1, 1};
    exp_t e;
    bus.mode = ANIM_ONESHOT; bus.rate = '0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      e.frame = fr[i]; e.base = base_of(1, fr[i]); e.done = dn[i];
      sb.push_back(e);
      pulse_once();
      e = sb.pop_front();
      checks++; if (int'(bus.frame_idx) !== e.frame) begin errors++; $display("FAIL os_frame[%0d] got %0d exp %0d", i, bus.frame_idx, e.frame); end
      checks++; if (int'(bus.done) !== e.done) begin errors++; $display("FAIL os_done[%0d] got %0b exp %0d", i, bus.done, e.done); end
    end
    checks++; if (int'(bus.cycle_cnt) !== STATS) begin errors++; $display("FAIL os_cycle got %0d exp %0d", bus.cycle_cnt, STATS); end
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    checks++; if (int'(bus.frame_idx) !== 0) begin errors++; $display("FAIL os_restart_frame got %0d exp 0", bus.frame_idx); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL os_restart_done got %0b exp 0", bus.done); end
    checks++; if (int'(bus.cycle_cnt) !== 0) begin errors++; $display("FAIL os_restart_cycle got %0d exp 0", bus.cycle_cnt); end
  endtask

  task automatic test_set_change();
    bus.mode = ANIM_LOOP; bus.set_sel = 1'b0; bus.rate = '0;
    repeat (3) tick();
    checks++; if (int'(bus.anim_base) !== 0) begin errors++; $display("FAIL sc_base0 got %0d exp 0", bus.anim_base); end
    bus.set_sel = 1'b1;
    pulse_once();
    checks++; if (int'(bus.frame_idx) !== 0) begin errors++; $display("FAIL sc_frame got %0d exp 0", bus.frame_idx); end
    checks++; if (int'(bus.anim_base) !== 0) begin errors++; $display("FAIL sc_base1 got %0d exp 0", bus.anim_base); end
    tick();
    checks++; if (int'(bus.anim_base) !== base_of(1, 0)) begin errors++; $display("FAIL sc_base2 got %0d exp %0d", bus.anim_base, base_of(1, 0)); end
  endtask

  task automatic test_hold();
    bus.mode = ANIM_HOLD; bus.set_sel = 1'b0; bus.sprite_addr = 14'd100;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      pulse_once();
      checks++; if (int'(bus.frame_idx) !== 0) begin errors++; $display("FAIL hold_frame[%0d] got %0d exp 0", i, bus.frame_idx); end
      checks++; if (int'(bus.anim_base) !== 0) begin errors++; $display("FAIL hold_base[%0d] got %0d exp 0", i, bus.anim_base); end
      checks++; if (int'(bus.rom_addr) !== 100) begin errors++; $display("FAIL hold_rom[%0d] got %0d exp 100", i, bus.rom_addr); end
    end
    bus.mode = ANIM_LOOP;
    tick();
    pulse_once();
    checks++; if (int'(bus.frame_idx) !== 1) begin errors++; $display("FAIL hold_resume_frame got %0d exp 1", bus.frame_idx); end
    tick();
    checks++; if (int'(bus.anim_base) !== base_of(0, 1)) begin errors++; $display("FAIL hold_resume_base got %0d exp %0d", bus.anim_base, base_of(0, 1)); end
    checks++; if (int'(bus.rom_addr) !== base_of(0, 1) + 100) begin errors++; $display("FAIL hold_resume_rom got %0d exp %0d", bus.rom_addr, base_of(0, 1) + 100); end
  endtask

  task automatic test_async_reset();
    bus.mode = ANIM_PINGPONG; bus.set_sel = 1'b0; bus.rate = '0;
    repeat (2) tick();
    pulse_once();
    pulse_once();
    checks++; if (int'(bus.frame_idx) !== 2) begin errors++; $display("FAIL ar_pre_frame got %0d exp 2", bus.frame_idx); end
    tick();
    @(negedge clk);
    #2;
    bus.anim_pulse = 1'b1;
    resetN = 1'b0;
    #1;
    checks++; if (int'(bus.frame_idx) !== 0) begin errors++; $display("FAIL ar_frame got %0d exp 0", bus.frame_idx); end
    checks++; if (int'(bus.anim_base) !== 0) begin errors++; $display("FAIL ar_base got %0d exp 0", bus.anim_base); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ar_done got %0b exp 0", bus.done); end
    checks++; if (int'(bus.rom_addr) !== 100) begin errors++; $display("FAIL ar_rom got %0d exp 100", bus.rom_addr); end
    bus.anim_pulse = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) tick();
    pulse_once();
    checks++; if (int'(bus.frame_idx) !== 1) begin errors++; $display("FAIL ar_post_frame got %0d exp 1", bus.frame_idx); end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_pingpong();
    test_oneshot();
    test_set_change();
    test_hold();
    test_async_reset();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
